sdram_write: RTL and testbench
==============================

Name: sdram_write

Overview:
- SDRAM write-command sequencer; the write-side counterpart of the SDRAM read sequencer inside the sdram_ctrl library.
- On each granted request it issues ACTIVE, then BURST_LEN single-beat WRITE commands to consecutive columns, then PRECHARGE-all, then pulses done.
- It keeps an auto-incrementing linear bank/row/column pointer, which can be loaded while idle.
- Its command/address/data outputs feed the controller's command mux/arbiter.

Parameters:
- TRCD, 2: cycles from the ACTIVE command to the first WRITE command; legal range 2..15.
- TWR, 2: NOP cycles between the last WRITE and PRECHARGE; legal range 1..15.
- TRP, 2: cycles from the PRECHARGE command to the wr_done pulse; legal range 2..15.
- BURST_LEN, 4: WRITE beats per request; must be a power of 2, from 1 to 256.

Ports:
- sclk  in  1  system clock.
- srst  in  1  reset; synchronous, active-high.
- wr_en  in  1  write request; sampled in IDLE only.
- wr_done  out  1  one-cycle pulse at the end of the sequence.
- i_wr_addr_ld  in  1  load the address pointer; honoured in IDLE only.
- i_wr_addr  in  21  load value {ba[1:0], row[10:0], col[7:0]}.
- i_wr_data  in  32  write data; upstream is a first-word-fall-through FIFO.
- o_wr_data_req  out  1  data consume strobe, one per beat.
- o_wr_data  out  32  data driven to the SDRAM DQ bus.
- o_wr_oe_n  out  1  DQ output enable, active low.
- o_wr_addr  out  11  SDRAM address bus.
- o_wr_ba  out  2  bank address.
- o_wr_dqm  out  4  byte masks.
- o_wr_cs_n, o_wr_ras_n, o_wr_cas_n, o_wr_we_n  out  1 each  command pins.

Behaviour:
- States: IDLE, ACTIVE, TRCD_W, WRITE, TWR_W, PRECH, TRP_W, DONE. One shared 8-bit wait/beat counter.
- IDLE:
  - wr_en=1 -> ACTIVE.
  - If i_wr_addr_ld=1 on the same cycle, the pointer loads i_wr_addr and the new address is used for this request.
- ACTIVE (1 cycle):
  - {cs,ras,cas,we}_n = 0011, o_wr_addr = row, o_wr_ba = bank.
- TRCD_W: NOP (0111) for TRCD-1 cycles.
- WRITE (BURST_LEN cycles); each cycle:
  - command 0100; o_wr_addr = {3'b000, col}, so A10=0 and there is no auto-precharge.
  - o_wr_data_req=1, o_wr_data=i_wr_data (combinational pass-through), o_wr_oe_n=0, o_wr_dqm=4'b0000.
  - The pointer increments by 1 at the end of the cycle.
- TWR_W: NOP for TWR cycles.
- PRECH (1 cycle): command 0010, o_wr_addr = 11'h400 (A10=1, all banks).
- TRP_W: NOP for TRP-1 cycles.
- DONE (1 cycle): wr_done=1, NOP -> IDLE.
- Latency, with ACTIVE at cycle t0:
  - WRITEs at t0+TRCD .. t0+TRCD+BURST_LEN-1.
  - PRECH at t0+TRCD+BURST_LEN+TWR.
  - wr_done at PRECH+TRP.
  - Back-to-back: the earliest next ACTIVE is 2 cycles after wr_done.
- Outside WRITE: o_wr_data=0, o_wr_data_req=0, o_wr_oe_n=1, o_wr_dqm=4'b1111.
- IDLE outputs: command 1000 (deselect), o_wr_addr=0, o_wr_ba = pointer bank.
- wr_en and i_wr_addr_ld outside IDLE are ignored, with no queuing.
- Pointer:
  - 21-bit linear counter with natural wrap: {3,2047,255} + 1 -> 0.
  - A burst never crosses a row, given BURST_LEN is a power of 2 and the start address is aligned.
  - A load value that is not burst-aligned is truncated: its low log2(BURST_LEN) bits are cleared.
- Reset (srst=1 at any clock edge, including mid-burst):
  - State -> IDLE, pointer -> 0, counter -> 0.
  - All outputs take their IDLE values: wr_done=0, o_wr_data_req=0, o_wr_oe_n=1, o_wr_dqm=4'hF, command 1000.
  - No PRECHARGE is issued on reset; the controller re-runs init.

Test Plan:
1. Reset, then pulse wr_en at cycle k (defaults) -> ACTIVE at k+1 with row 0 / bank 0; WRITEs at k+3..k+6 with cols 0..3 and data_req high; PRECH at k+9 with addr 0x400; wr_done at k+11 only.
2. Feed data 0xA0..0xA3 on the beats -> o_wr_data matches on each beat with oe_n=0 and dqm=0; outside WRITE, data=0, oe_n=1, dqm=F.
3. 64 consecutive requests -> the 65th ACTIVE drives row 1, col 0; the pointer never lands on col 256.
4. Load 0x1FFFFC, then request -> bank 3, row 2047, cols 252..255; the next request uses bank 0, row 0, col 0.
5. Assert srst during the 2nd WRITE beat -> the next cycle shows command 1000, data_req=0, wr_done=0; a fresh request starts at col 0.
6. wr_en or i_wr_addr_ld pulsed during TWR_W -> ignored: no extra sequence and the pointer is unchanged.

Source files
------------

// File: rtl/sdram_write_if.sv
// Bus bundle between the SDRAM write sequencer and its neighbours.
// The master side is the request/data producer. The slave side is the sequencer.
interface sdram_write_if;
    logic        wr_en;
    logic        wr_done;
    logic        i_wr_addr_ld;
    logic [20:0] i_wr_addr;
    logic [31:0] i_wr_data;
    logic        o_wr_data_req;
    logic [31:0] o_wr_data;
    logic        o_wr_oe_n;
    logic [10:0] o_wr_addr;
    logic [1:0]  o_wr_ba;
    logic [3:0]  o_wr_dqm;
    logic        o_wr_cs_n;
    logic        o_wr_ras_n;
    logic        o_wr_cas_n;
    logic        o_wr_we_n;

    modport master (
        output wr_en, i_wr_addr_ld, i_wr_addr, i_wr_data,
        input  wr_done, o_wr_data_req, o_wr_data, o_wr_oe_n, o_wr_addr,
               o_wr_ba, o_wr_dqm, o_wr_cs_n, o_wr_ras_n, o_wr_cas_n, o_wr_we_n
    );

    modport slave (
        input  wr_en, i_wr_addr_ld, i_wr_addr, i_wr_data,
        output wr_done, o_wr_data_req, o_wr_data, o_wr_oe_n, o_wr_addr,
               o_wr_ba, o_wr_dqm, o_wr_cs_n, o_wr_ras_n, o_wr_cas_n, o_wr_we_n
    );
endinterface

// File: rtl/sdram_write.sv
// SDRAM write-command sequencer.
// Each accepted request produces this sequence:
//   ACTIVE, BURST_LEN WRITE beats to consecutive columns, PRECHARGE-all, then a done pulse.
// A linear bank/row/col pointer advances once per beat. It can be loaded while idle.
module sdram_write #(
    parameter int TRCD      = 2,
    parameter int TWR       = 2,
    parameter int TRP       = 2,
    parameter int BURST_LEN = 4
) (
    input  logic          sclk,
    input  logic          srst,
    sdram_write_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_ACTIVE, S_TRCD_W, S_WRITE, S_TWR_W, S_PRECH, S_TRP_W, S_DONE
    } state_t;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_DESEL = 4'b1000;
    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_ACT   = 4'b0011;
    localparam logic [3:0] CMD_WRITE = 4'b0100;
    localparam logic [3:0] CMD_PRE   = 4'b0010;

    // Clearing the low bits keeps a burst inside one row.
    localparam logic [20:0] ALIGN_MASK = ~21'(BURST_LEN - 1);

    // Counter reload values. Each wait state leaves when the counter reads 0.
    // The ACTIVE and PRECH cycles count toward TRCD and TRP.
    localparam logic [7:0] TRCD_LD = 8'(TRCD - 2);
    localparam logic [7:0] BEAT_LD = 8'(BURST_LEN - 1);
    localparam logic [7:0] TWR_LD  = 8'(TWR - 1);
    localparam logic [7:0] TRP_LD  = 8'(TRP - 2);

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic [20:0] r_ptr;
    logic [3:0]  r_cmd;
    logic [10:0] r_addr;
    logic        r_done;
    logic        r_wbeat;

    logic [20:0] w_ld_addr;
    logic [20:0] w_ptr_start;
    logic [20:0] w_ptr_inc;

    assign w_ld_addr   = bus.i_wr_addr & ALIGN_MASK;
    assign w_ptr_start = bus.i_wr_addr_ld ? w_ld_addr : r_ptr;
    assign w_ptr_inc   = r_ptr + 21'd1;

    // Data-path outputs all follow the registered beat flag.
    // Write data is a pass-through from the FWFT FIFO head.
    assign bus.o_wr_data_req = r_wbeat;
    assign bus.o_wr_oe_n     = ~r_wbeat;
    assign bus.o_wr_dqm      = {4{~r_wbeat}};
    assign bus.o_wr_data     = r_wbeat ? bus.i_wr_data : 32'd0;
    assign bus.o_wr_ba       = r_ptr[20:19];
    assign bus.o_wr_addr     = r_addr;
    assign bus.wr_done       = r_done;
    assign bus.o_wr_cs_n     = r_cmd[3];
    assign bus.o_wr_ras_n    = r_cmd[2];
    assign bus.o_wr_cas_n    = r_cmd[1];
    assign bus.o_wr_we_n     = r_cmd[0];

    // Sequencer FSM.
    // Every output register is loaded with the value for the state being entered.
    always_ff @(posedge sclk) begin
        if (srst) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
            r_ptr   <= 21'd0;
            r_cmd   <= CMD_DESEL;
            r_addr  <= 11'd0;
            r_done  <= 1'b0;
            r_wbeat <= 1'b0;
        end else begin
            r_cmd   <= CMD_NOP;
            r_addr  <= 11'd0;
            r_done  <= 1'b0;
            r_wbeat <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_ptr <= w_ptr_start;
                    if (bus.wr_en) begin
                        r_state <= S_ACTIVE;
                        r_cmd   <= CMD_ACT;
                        r_addr  <= w_ptr_start[18:8];
                    end else begin
                        r_cmd <= CMD_DESEL;
                    end
                end
                S_ACTIVE: begin
                    r_state <= S_TRCD_W;
                    r_cnt   <= TRCD_LD;
                end
                S_TRCD_W: begin
                    if (r_cnt == 8'd0) begin
                        r_state <= S_WRITE;
                        r_cnt   <= BEAT_LD;
                        r_cmd   <= CMD_WRITE;
                        r_addr  <= {3'b000, r_ptr[7:0]};
                        r_wbeat <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_WRITE: begin
                    r_ptr <= w_ptr_inc;
                    if (r_cnt == 8'd0) begin
                        r_state <= S_TWR_W;
                        r_cnt   <= TWR_LD;
                    end else begin
                        r_cnt   <= r_cnt - 8'd1;
                        r_cmd   <= CMD_WRITE;
                        r_addr  <= {3'b000, w_ptr_inc[7:0]};
                        r_wbeat <= 1'b1;
                    end
                end
                S_TWR_W: begin
                    if (r_cnt == 8'd0) begin
                        r_state <= S_PRECH;
                        r_cmd   <= CMD_PRE;
                        r_addr  <= 11'h400;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_PRECH: begin
                    r_state <= S_TRP_W;
                    r_cnt   <= TRP_LD;
                end
                S_TRP_W: begin
                    if (r_cnt == 8'd0) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_cmd   <= CMD_DESEL;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cmd   <= CMD_DESEL;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sdram_write.sv
// Testbench for sdram_write.
// A cycle-level reference model tracks each request by its offset from the ACTIVE cycle.
// Every cycle, all outputs are compared against the model.
module tb_sdram_write;
    localparam int TRCD   = 2;
    localparam int TWR    = 2;
    localparam int TRP    = 2;
    localparam int BL     = 4;
    localparam int T_PRE  = TRCD + BL + TWR;
    localparam int T_DONE = T_PRE + TRP;
    localparam logic [20:0] AMASK = ~21'(BL - 1);

    logic sclk = 1'b0;
    logic srst;
    sdram_write_if bus();

    sdram_write #(.TRCD(TRCD), .TWR(TWR), .TRP(TRP), .BURST_LEN(BL)) dut (
        .sclk(sclk),
        .srst(srst),
        .bus (bus)
    );

    always #5 sclk = ~sclk;

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    bit          m_busy  = 1'b0;
    int          m_off   = 0;
    logic [20:0] m_start = 21'd0;
    logic [20:0] m_ptr   = 21'd0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock cycle.
    // Drive the inputs, compare the outputs against the model, then advance the model.
    task automatic cycle(input bit en, input bit ld, input logic [20:0] addr,
                         input bit rst, input bit pat);
        bit          wr;
        bit          chk_ba;
        int          beat;
        logic [20:0] a;
        logic [3:0]  e_cmd;
        logic [10:0] e_addr;
        logic [1:0]  e_ba;
        logic        e_done;
        @(negedge sclk);
        beat = m_off - TRCD;
        wr   = m_busy && (m_off >= TRCD) && (m_off < TRCD + BL);
        bus.wr_en        = en;
        bus.i_wr_addr_ld = ld;
        bus.i_wr_addr    = addr;
        bus.i_wr_data    = (pat && wr) ? 32'hA0 + 32'(beat) : $urandom;
        srst             = rst;
        #1;
        e_cmd  = 4'b1000;
        e_addr = 11'd0;
        e_ba   = m_ptr[20:19];
        e_done = 1'b0;
        chk_ba = 1'b1;
        if (m_busy) begin
            e_cmd  = 4'b0111;
            chk_ba = 1'b0;
            if (m_off == 0) begin
                e_cmd  = 4'b0011;
                e_addr = m_start[18:8];
                e_ba   = m_start[20:19];
                chk_ba = 1'b1;
            end else if (wr) begin
                a      = m_start + 21'(beat);
                e_cmd  = 4'b0100;
                e_addr = {3'b000, a[7:0]};
                e_ba   = a[20:19];
                chk_ba = 1'b1;
            end else if (m_off == T_PRE) begin
                e_cmd  = 4'b0010;
                e_addr = 11'h400;
            end else if (m_off == T_DONE) begin
                e_done = 1'b1;
            end
        end
        chk("cmd", {28'd0, bus.o_wr_cs_n, bus.o_wr_ras_n, bus.o_wr_cas_n, bus.o_wr_we_n}, {28'd0, e_cmd});
        chk("addr", {21'd0, bus.o_wr_addr}, {21'd0, e_addr});
        if (chk_ba) chk("ba", {30'd0, bus.o_wr_ba}, {30'd0, e_ba});
        chk("done", {31'd0, bus.wr_done}, {31'd0, e_done});
        chk("data_req", {31'd0, bus.o_wr_data_req}, {31'd0, wr});
        chk("oe_n", {31'd0, bus.o_wr_oe_n}, {31'd0, !wr});
        chk("dqm", {28'd0, bus.o_wr_dqm}, wr ? 32'h0 : 32'hF);
        chk("data", bus.o_wr_data, wr ? bus.i_wr_data : 32'd0);
        // Advance the model past the upcoming clock edge.
        if (rst) begin
            m_busy = 1'b0;
            m_ptr  = 21'd0;
        end else if (m_busy) begin
            if (m_off == T_DONE) m_busy = 1'b0;
            else m_off++;
        end else begin
            if (ld) m_ptr = addr & AMASK;
            if (en) begin
                m_start = m_ptr;
                m_ptr   = m_ptr + 21'(BL);
                m_busy  = 1'b1;
                m_off   = 0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 21'd0, 1'b0, 1'b1);
    endtask

    // Issue one request, then run the sequence through its done cycle.
    task automatic request(input bit ld, input logic [20:0] addr);
        cycle(1'b1, ld, addr, 1'b0, 1'b1);
        idle(T_DONE + 1);
    endtask

    initial begin
        srst             = 1'b1;
        bus.wr_en        = 1'b0;
        bus.i_wr_addr_ld = 1'b0;
        bus.i_wr_addr    = 21'd0;
        bus.i_wr_data    = 32'd0;
        repeat (3) @(posedge sclk);

        // Reset state, followed by a default request with a data pattern.
        idle(2);
        request(1'b0, 21'd0);
        idle(1);

        // Back-to-back requests: the pointer walks across the row boundary.
        for (int r = 0; r < 64; r++) request(1'b0, 21'd0);

        // Load at the top of the address space, then wrap to zero.
        request(1'b1, 21'h1FFFFC);
        request(1'b0, 21'd0);

        // A misaligned load must be truncated.
        request(1'b1, 21'h0ABC7);

        // Reset during the second WRITE beat.
        cycle(1'b1, 1'b0, 21'd0, 1'b0, 1'b1);
        idle(TRCD + 1);
        cycle(1'b0, 1'b0, 21'd0, 1'b1, 1'b1);
        idle(1);
        request(1'b0, 21'd0);

        // wr_en and load pulsed during TWR_W must be ignored.
        cycle(1'b1, 1'b0, 21'd0, 1'b0, 1'b1);
        idle(TRCD + BL);
        cycle(1'b1, 1'b1, 21'h12345, 1'b0, 1'b1);
        idle(T_DONE - TRCD - BL);
        idle(4);

        // Randomized traffic.
        for (int i = 0; i < 600; i++)
            cycle(($urandom % 4) == 0, ($urandom % 3) == 0, 21'($urandom),
                  ($urandom % 97) == 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
